regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (WE/RW_no/Din) between NREQ writeback requesters, such as the ALU, load unit and link/syscall unit.
- Round-robin arbitration feeds a DEPTH-entry in-order write queue.
- The queue drains into the register file when drain_en allows.
- Publishes a pending-register mask and a newest-value forwarding lookup so decode can detect and bypass queued writes.

---
 rtl/regwb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// Shared register-file writeback definitions: widths, the zero register and a
// one-hot register decode used for the pending-write mask.
package regwb_pkg;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int NUM_REGS = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [AW-1:0] no);
        logic [NUM_REGS-1:0] oh;
        oh     = '0;
        oh[no] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant for the writeback requesters: the search starts at rr_ptr
// and the pointer moves just past the winner on every transfer.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            full,
    output logic [NREQ-1:0] grant
);
    import regwb_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win_idx;
    logic          win_vld;
    int            cand;

    always_comb begin
        grant   = '0;
        win_idx = rr_ptr;
        win_vld = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = PW'(cand);
            end
        end
        // No grant while the queue is full or the block is held in reset.
        if (win_vld && !full && reset)
            grant[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (win_vld && !full)
            rr_ptr <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources through an
// in-order write queue, exposing pending-register and forwarding lookups.
module regfile_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*AW-1:0]     req_no,
    input  logic [NREQ*DW-1:0]     req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   drain_en,
    output logic                   wb_we,
    output logic [AW-1:0]          wb_no,
    output logic [DW-1:0]          wb_din,
    input  logic [AW-1:0]          fwd_no,
    output logic                   fwd_hit,
    output logic [DW-1:0]          fwd_data,
    output logic [31:0]            pending_mask,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    import regwb_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_no   [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] scan_idx;
    logic [AW-1:0] sel_no;
    logic [DW-1:0] sel_data;
    logic          push;
    logic          pop;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .full  (full),
        .grant (req_ready)
    );

    always_comb begin
        sel_no   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_no   = req_no[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Writes to r0 complete the handshake but never enter the queue.
    assign push  = (|req_ready) && (sel_no != REG_ZERO);
    assign pop   = drain_en && !empty;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Queue control and the write-port stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            wb_we  <= 1'b0;
            wb_no  <= '0;
            wb_din <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop) begin
                head   <= head + 1'b1;
                wb_we  <= 1'b1;
                wb_no  <= q_no[head];
                wb_din <= q_data[head];
            end else begin
                wb_we  <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_no[tail]   <= sel_no;
            q_data[tail] <= sel_data;
        end
    end

    // Scan oldest to youngest so the youngest matching entry ends up winning.
    always_comb begin
        pending_mask = '0;
        fwd_hit      = 1'b0;
        fwd_data     = '0;
        scan_idx     = head;
        if (wb_we) begin
            pending_mask = onehot_reg(wb_no);
            if (wb_no == fwd_no) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_din;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if (k < int'(count)) begin
                pending_mask = pending_mask | onehot_reg(q_no[scan_idx]);
                if (q_no[scan_idx] == fwd_no) begin
                    fwd_hit  = 1'b1;
                    fwd_data = q_data[scan_idx];
                end
            end
        end
        if (fwd_no == REG_ZERO) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based reference model is
// compared every negedge, plus literal expectations at key points.
module tb_regfile_wb_arbiter;

    localparam int NREQ  = 3;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*AW-1:0]   req_no = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 drain_en = 1'b0;
    logic                 wb_we;
    logic [AW-1:0]        wb_no;
    logic [DW-1:0]        wb_din;
    logic [AW-1:0]        fwd_no = '0;
    logic                 fwd_hit;
    logic [DW-1:0]        fwd_data;
    logic [31:0]          pending_mask;
    logic [$clog2(DEPTH):0] count;
    logic                 full;
    logic                 empty;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_no       (req_no),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .drain_en     (drain_en),
        .wb_we        (wb_we),
        .wb_no        (wb_no),
        .wb_din       (wb_din),
        .fwd_no       (fwd_no),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .pending_mask (pending_mask),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] no;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           mq[$];
    int            m_rr = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_no = '0;
    logic [DW-1:0] m_din = '0;

    function automatic int m_winner();
        int i;
        if (!reset || mq.size() >= DEPTH) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_rr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    initial begin : model
        int  w;
        wr_t h;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mq.delete();
                m_rr  = 0;
                m_we  = 1'b0;
                m_no  = '0;
                m_din = '0;
            end else begin
                w = m_winner();
                if (drain_en && mq.size() > 0) begin
                    h     = mq.pop_front();
                    m_we  = 1'b1;
                    m_no  = h.no;
                    m_din = h.d;
                end else begin
                    m_we = 1'b0;
                end
                if (w >= 0) begin
                    m_rr = (w + 1) % NREQ;
                    if (req_no[w*AW +: AW] != '0)
                        mq.push_back({req_no[w*AW +: AW], req_data[w*DW +: DW]});
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] e_rdy;
        logic [31:0]     e_mask;
        logic            e_hit;
        logic [DW-1:0]   e_fd;
        int              w;
        w     = m_winner();
        e_rdy = '0;
        if (w >= 0) e_rdy[w] = 1'b1;
        e_mask = '0;
        if (m_we) e_mask[m_no] = 1'b1;
        foreach (mq[i]) e_mask[mq[i].no] = 1'b1;
        e_hit = 1'b0;
        e_fd  = '0;
        if (fwd_no != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!e_hit && mq[i].no == fwd_no) begin
                    e_hit = 1'b1;
                    e_fd  = mq[i].d;
                end
            end
            if (!e_hit && m_we && m_no == fwd_no) begin
                e_hit = 1'b1;
                e_fd  = m_din;
            end
        end
        check("m_ready",   64'(req_ready),    64'(e_rdy));
        check("m_wb_we",   64'(wb_we),        64'(m_we));
        check("m_wb_no",   64'(wb_no),        64'(m_no));
        check("m_wb_din",  64'(wb_din),       64'(m_din));
        check("m_count",   64'(count),        64'(mq.size()));
        check("m_full",    64'(full),         64'(mq.size() == DEPTH));
        check("m_empty",   64'(empty),        64'(mq.size() == 0));
        check("m_mask",    64'(pending_mask), 64'(e_mask));
        check("m_fwd_hit", 64'(fwd_hit),      64'(e_hit));
        check("m_fwd_dat", 64'(fwd_data),     64'(e_fd));
    endtask

    initial begin : comparer
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] no, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_no[i*AW +: AW]   = no;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin : stim
        set_req(0, 1'b1, 5'd1, 32'hA);
        set_req(1, 1'b1, 5'd2, 32'hB);
        set_req(2, 1'b1, 5'd3, 32'hC);
        fwd_no = 5'd9;

        // Reset held with every requester asking
        repeat (2) cyc();
        #1;
        check("rst_ready", 64'(req_ready),    64'(3'b000));
        check("rst_wb_we", 64'(wb_we),        64'(1'b0));
        check("rst_empty", 64'(empty),        64'(1'b1));
        check("rst_mask",  64'(pending_mask), 64'(32'h0));
        reset = 1'b1;
        #1;
        check("first_grant", 64'(req_ready), 64'(3'b001));
        drain_en = 1'b1;

        // Round-robin rotation with issue one cycle after acceptance
        cyc(); #1;
        check("rr_ready1", 64'(req_ready), 64'(3'b010));
        check("rr_wb_we1", 64'(wb_we),     64'(1'b0));
        cyc(); #1;
        check("rr_ready2", 64'(req_ready), 64'(3'b100));
        check("rr_wb1",    64'({wb_we, wb_no, wb_din}), 64'({1'b1, 5'd1, 32'hA}));
        cyc(); #1;
        check("rr_ready3", 64'(req_ready), 64'(3'b001));
        check("rr_wb2",    64'({wb_we, wb_no, wb_din}), 64'({1'b1, 5'd2, 32'hB}));
        cyc(); #1;
        check("rr_ready4", 64'(req_ready), 64'(3'b010));
        check("rr_wb3",    64'({wb_we, wb_no, wb_din}), 64'({1'b1, 5'd3, 32'hC}));
        req_valid = '0;
        repeat (2) cyc();
        #1;
        check("rr_idle", 64'({wb_we, empty}), 64'(2'b01));

        // Fill to full with drain disabled
        drain_en = 1'b0;
        for (int r = 5; r <= 8; r++) begin
            set_req(1, 1'b1, AW'(r), DW'(r * 16));
            cyc();
        end
        set_req(1, 1'b1, 5'd9, 32'h90);
        #1;
        check("full_count", 64'(count),        64'(3'd4));
        check("full_flag",  64'(full),         64'(1'b1));
        check("full_ready", 64'(req_ready),    64'(3'b000));
        check("full_mask",  64'(pending_mask), 64'(32'h000001E0));
        drain_en = 1'b1;
        #1;
        check("full_nopass", 64'(req_ready), 64'(3'b000));
        cyc(); #1;
        check("drain_wb",    64'({wb_we, wb_no, wb_din}), 64'({1'b1, 5'd5, 32'h50}));
        check("drain_count", 64'(count),     64'(3'd3));
        check("drain_ready", 64'(req_ready), 64'(3'b010));
        cyc();
        set_req(1, 1'b0, 5'd0, 32'h0);
        repeat (5) cyc();
        #1;
        check("drained", 64'({wb_we, empty}), 64'(2'b01));

        // Register 0 is accepted and dropped
        set_req(0, 1'b1, 5'd0, 32'hFFFF);
        #1;
        check("r0_ready", 64'(req_ready), 64'(3'b001));
        cyc();
        set_req(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("r0_count", 64'(count),        64'(3'd0));
        check("r0_mask",  64'(pending_mask), 64'(32'h0));
        cyc(); #1;
        check("r0_no_we", 64'(wb_we), 64'(1'b0));

        // Forwarding picks the newest write to r9
        drain_en = 1'b0;
        fwd_no   = 5'd9;
        set_req(1, 1'b1, 5'd9, 32'h11);
        cyc();
        set_req(1, 1'b1, 5'd9, 32'h22);
        cyc();
        set_req(1, 1'b0, 5'd9, 32'h22);
        #1;
        check("fwd_q2",   64'({fwd_hit, fwd_data}), 64'({1'b1, 32'h22}));
        check("fwd_mask", 64'(pending_mask),        64'(32'h00000200));
        drain_en = 1'b1;
        cyc(); #1;
        check("fwd_q1",   64'({fwd_hit, fwd_data}), 64'({1'b1, 32'h22}));
        check("fwd_wb11", 64'(wb_din),              64'(32'h11));
        cyc(); #1;
        check("fwd_wb",   64'({fwd_hit, fwd_data, wb_we}), 64'({1'b1, 32'h22, 1'b1}));
        cyc(); #1;
        check("fwd_gone", 64'({fwd_hit, fwd_data}), 64'({1'b0, 32'h0}));

        // Asynchronous reset in the middle of a drain
        drain_en = 1'b0;
        for (int r = 10; r <= 12; r++) begin
            set_req(2, 1'b1, AW'(r), DW'(256 + r));
            cyc();
        end
        set_req(2, 1'b1, 5'd13, 32'h10D);
        drain_en = 1'b1;
        cyc();
        set_req(2, 1'b0, 5'd0, 32'h0);
        #1;
        check("ar_pre", 64'({count, wb_we, wb_no}), 64'({3'd3, 1'b1, 5'd10}));
        reset = 1'b0;
        #1;
        check("ar_we",    64'(wb_we),            64'(1'b0));
        check("ar_count", 64'({count, empty}),   64'({3'd0, 1'b1}));
        check("ar_mask",  64'(pending_mask),     64'(32'h0));
        #1;
        reset = 1'b1;
        repeat (3) cyc();
        #1;
        check("ar_quiet", 64'({wb_we, count}), 64'({1'b0, 3'd0}));

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
